// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: arbitrates data-memory wait states, load-use hazards and ID flushes.
// Optional HAZARD_PERF_EN adds saturating stall/flush performance counters.
module hazard_stall_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd,
   input  logic             flush_req,
   input  logic             mem_access,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_write,
   output logic             id_ex_bubble,
   output logic             ex_mem_write,
   output logic             mem_wb_write,
   output logic             mem_wb_bubble,
   output logic             mem_req,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      RUN,
      MEM_WAIT,
      ABORT
   } state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              flush_pending_q, flush_pending_d;
   logic              mem_err_q, mem_err_d;
   logic              load_use;
   logic [WAIT_W-1:0] frozen_cnt;

   assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));

   // wait_q counts frozen cycles already spent on the current access; the RUN entry cycle is the first
   assign frozen_cnt = (state_q == MEM_WAIT) ? (wait_q + WAIT_W'(1)) : WAIT_W'(1);

   always_comb begin
      state_d         = state_q;
      wait_d          = wait_q;
      flush_pending_d = flush_pending_q;
      mem_err_d       = mem_err_q;
      pc_write        = 1'b1;
      if_id_write     = 1'b1;
      if_id_flush     = 1'b0;
      id_ex_write     = 1'b1;
      id_ex_bubble    = 1'b0;
      ex_mem_write    = 1'b1;
      mem_wb_write    = 1'b1;
      mem_wb_bubble   = 1'b0;
      mem_req         = 1'b0;

      if (rst) begin
         pc_write        = 1'b0;
         if_id_write     = 1'b0;
         id_ex_write     = 1'b0;
         ex_mem_write    = 1'b0;
         mem_wb_write    = 1'b0;
         if_id_flush     = 1'b1;
         id_ex_bubble    = 1'b1;
         mem_wb_bubble   = 1'b1;
         state_d         = RUN;
         wait_d          = '0;
         flush_pending_d = 1'b0;
         mem_err_d       = 1'b0;
      end else begin
         case (state_q)
            RUN, MEM_WAIT: begin
               if (mem_access || (state_q == MEM_WAIT)) begin
                  mem_req = 1'b1;
               end
               if ((mem_access || (state_q == MEM_WAIT)) && !mem_ready) begin
                  pc_write        = 1'b0;
                  if_id_write     = 1'b0;
                  id_ex_write     = 1'b0;
                  ex_mem_write    = 1'b0;
                  mem_wb_bubble   = 1'b1;
                  flush_pending_d = flush_pending_q || flush_req;
                  if (frozen_cnt >= WAIT_LIMIT) begin
                     state_d   = ABORT;
                     wait_d    = '0;
                     mem_err_d = 1'b1;
                  end else begin
                     state_d = MEM_WAIT;
                     wait_d  = frozen_cnt;
                  end
               end else if (state_q == MEM_WAIT) begin
                  // Release cycle: everything advances and any flush seen while frozen is applied now
                  if_id_flush     = flush_pending_q || flush_req;
                  flush_pending_d = 1'b0;
                  wait_d          = '0;
                  state_d         = RUN;
               end else if (load_use) begin
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_bubble = 1'b1;
               end else if (flush_req) begin
                  if_id_flush = 1'b1;
               end
            end
            ABORT: begin
               mem_wb_bubble   = 1'b1;
               if_id_flush     = flush_pending_q || flush_req;
               flush_pending_d = 1'b0;
               state_d         = RUN;
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= RUN;
         wait_q          <= '0;
         flush_pending_q <= 1'b0;
         mem_err_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         wait_q          <= wait_d;
         flush_pending_q <= flush_pending_d;
         mem_err_q       <= mem_err_d;
      end
   end

   assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] flush_count_q, flush_count_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (!pc_write && (stall_cycles_q != {CNT_W{1'b1}})) begin
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
      if (if_id_flush && (flush_count_q != {CNT_W{1'b1}})) begin
         flush_count_d = flush_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomized plus directed bench for hazard_stall_ctrl against a cycle-level behavioural model.
// Build with +define+HAZARD_PERF_EN to also check the performance counters.
module tb_hazard_stall_ctrl;

   localparam int MEM_TIMEOUT = 16;
   localparam int CNT_W       = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [4:0]       idRs1, idRs2, exRd;
   logic             idUseRs1, idUseRs2, exMemRead, flushReq, memAccess, memReady;
   logic             pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExBubble;
   logic             exMemWrite, memWbWrite, memWbBubble, memReq, memErr;
   logic [CNT_W-1:0] stallCycles, flushCount;

   int compared   = 0;
   int mismatched = 0;

   // Behavioural model state: where the current access stands and what has been observed so far
   bit          mWaiting, mAborting, mPending, mErr;
   int          mFrozen;
   int unsigned mStalls, mFlushes;

   hazard_stall_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(idRs1), .id_rs2(idRs2), .id_use_rs1(idUseRs1), .id_use_rs2(idUseRs2),
      .ex_mem_read(exMemRead), .ex_rd(exRd), .flush_req(flushReq),
      .mem_access(memAccess), .mem_ready(memReady),
      .pc_write(pcWrite), .if_id_write(ifIdWrite), .if_id_flush(ifIdFlush),
      .id_ex_write(idExWrite), .id_ex_bubble(idExBubble), .ex_mem_write(exMemWrite),
      .mem_wb_write(memWbWrite), .mem_wb_bubble(memWbBubble), .mem_req(memReq),
      .mem_err(memErr), .stall_cycles(stallCycles), .flush_count(flushCount)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Drives one cycle of inputs, checks every output against the model, then advances the model
   task automatic applyStimulus(input bit r, input bit [4:0] rs1, input bit [4:0] rs2, input bit u1,
                                input bit u2, input bit ld, input bit [4:0] rd, input bit fl,
                                input bit acc, input bit rdy);
      bit hz, ePc, eIfId, eFlush, eIdEx, eIdBub, eExMem, eMemWb, eWbBub, eReq;
      int n;
      @(negedge clk);
      rst = r; idRs1 = rs1; idRs2 = rs2; idUseRs1 = u1; idUseRs2 = u2;
      exMemRead = ld; exRd = rd; flushReq = fl; memAccess = acc; memReady = rdy;
      #1;
      hz = ld && (rd != 0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
      ePc = 1; eIfId = 1; eFlush = 0; eIdEx = 1; eIdBub = 0;
      eExMem = 1; eMemWb = 1; eWbBub = 0; eReq = 0;
      if (r) begin
         ePc = 0; eIfId = 0; eIdEx = 0; eExMem = 0; eMemWb = 0;
         eFlush = 1; eIdBub = 1; eWbBub = 1;
      end else if (mAborting) begin
         eWbBub = 1;
         eFlush = mPending || fl;
      end else if ((mWaiting || acc) && !rdy) begin
         ePc = 0; eIfId = 0; eIdEx = 0; eExMem = 0; eWbBub = 1; eReq = 1;
      end else if (mWaiting) begin
         eReq = 1;
         eFlush = mPending || fl;
      end else begin
         eReq = acc;
         if (hz) begin
            ePc = 0; eIfId = 0; eIdBub = 1;
         end else if (fl) begin
            eFlush = 1;
         end
      end

      checkOutput("pc_write", pcWrite, ePc);
      checkOutput("if_id_write", ifIdWrite, eIfId);
      checkOutput("if_id_flush", ifIdFlush, eFlush);
      checkOutput("id_ex_write", idExWrite, eIdEx);
      checkOutput("id_ex_bubble", idExBubble, eIdBub);
      checkOutput("ex_mem_write", exMemWrite, eExMem);
      checkOutput("mem_wb_write", memWbWrite, eMemWb);
      checkOutput("mem_wb_bubble", memWbBubble, eWbBub);
      checkOutput("mem_req", memReq, eReq);
      checkOutput("mem_err", memErr, mErr);
`ifdef HAZARD_PERF_EN
      checkOutput("stall_cycles", stallCycles, mStalls);
      checkOutput("flush_count", flushCount, mFlushes);
`else
      checkOutput("stall_cycles", stallCycles, 0);
      checkOutput("flush_count", flushCount, 0);
`endif

      if (r) begin
         mWaiting = 0; mAborting = 0; mPending = 0; mErr = 0; mFrozen = 0;
         mStalls = 0; mFlushes = 0;
      end else begin
         if (!ePc && mStalls != 32'hFFFF_FFFF) mStalls++;
         if (eFlush && mFlushes != 32'hFFFF_FFFF) mFlushes++;
         if (mAborting) begin
            mAborting = 0; mPending = 0;
         end else if ((mWaiting || acc) && !rdy) begin
            n = mWaiting ? mFrozen + 1 : 1;
            mPending = mPending || fl;
            if (n >= MEM_TIMEOUT - 1) begin
               mAborting = 1; mErr = 1; mWaiting = 0; mFrozen = 0;
            end else begin
               mWaiting = 1; mFrozen = n;
            end
         end else if (mWaiting) begin
            mWaiting = 0; mPending = 0; mFrozen = 0;
         end
      end
   endtask

   task automatic idleCycle(input bit acc, input bit rdy, input bit fl);
      applyStimulus(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, fl, acc, rdy);
   endtask

   initial begin
      int bias;
      rst = 1; idRs1 = 0; idRs2 = 0; idUseRs1 = 0; idUseRs2 = 0;
      exMemRead = 0; exRd = 0; flushReq = 0; memAccess = 0; memReady = 0;
      mWaiting = 0; mAborting = 0; mPending = 0; mErr = 0; mFrozen = 0;
      mStalls = 0; mFlushes = 0;
      repeat (2) @(posedge clk);

      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idleCycle(0, 0, 0);
      // Load-use on rs2, then the same with ex_rd = x0
      applyStimulus(0, 5'd3, 5'd5, 1, 1, 1, 5'd5, 0, 0, 0);
      idleCycle(0, 0, 0);
      applyStimulus(0, 5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 0);
      // Three-cycle memory wait then release
      repeat (3) idleCycle(1, 0, 0);
      idleCycle(1, 1, 0);
      // Flush pulsed in the second cycle of a four-cycle wait
      idleCycle(1, 0, 0);
      idleCycle(1, 0, 1);
      idleCycle(1, 0, 0);
      idleCycle(1, 0, 0);
      idleCycle(1, 1, 0);
      idleCycle(0, 0, 0);
      // Load-use and flush together
      applyStimulus(0, 5'd7, 5'd9, 1, 0, 1, 5'd7, 1, 0, 0);
      idleCycle(0, 0, 1);
      // Timeout, sticky error, then reset
      repeat (MEM_TIMEOUT - 1) idleCycle(1, 0, 0);
      idleCycle(0, 0, 0);
      repeat (3) idleCycle(0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idleCycle(0, 0, 0);
      // Reset in the middle of a wait with a pending flush
      idleCycle(1, 0, 1);
      idleCycle(1, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      idleCycle(0, 0, 0);

      bias = 6;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc % 60 == 0) bias = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(3, 9);
         applyStimulus($urandom_range(0, 99) == 0,
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                       $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                       $urandom_range(0, 9) < bias);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RISC-V core. Sits beside the decode-stage control unit and arbitrates the three pipeline-disturbing events: data-memory wait states, load-use data hazards, and the mispredict/jump flush request issued from ID. It drives per-stage register write enables, bubble/flush injects and the data-memory request handshake.

Parameters:
- MEM_TIMEOUT, 16: maximum wait cycles for mem_ready before abort (>=1).
- CNT_W, 32: width of the optional performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- id_rs1  in  5  rs1 of the instruction in ID
- id_rs2  in  5  rs2 of the instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of the EX instruction
- flush_req  in  1  flush request from the control unit (mispredict or jump in ID)
- mem_access  in  1  MEM-stage instruction is a load or store
- mem_ready  in  1  data-memory acknowledge
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  clear IF/ID to NOP
- id_ex_write  out  1  ID/EX register enable
- id_ex_bubble  out  1  load NOP into ID/EX
- ex_mem_write  out  1  EX/MEM register enable
- mem_wb_write  out  1  MEM/WB register enable
- mem_wb_bubble  out  1  load NOP into MEM/WB
- mem_req  out  1  data-memory request
- mem_err  out  1  sticky timeout flag
- stall_cycles  out  CNT_W  optional performance counter
- flush_count  out  CNT_W  optional performance counter

Behaviour:
- One clock, clk. rst is synchronous and active-high.
- The FSM has three states: RUN, MEM_WAIT and ABORT. On reset: state=RUN, wait counter=0, flush_pending=0, mem_err=0, counters=0.
- While rst=1, outputs are forced to: all *_write=0, if_id_flush=1, id_ex_bubble=1, mem_wb_bubble=1, mem_req=0.
- Default in RUN with no event: all *_write=1, and all bubble/flush outputs=0.
- mem_req = mem_access in RUN; mem_req=1 throughout MEM_WAIT.
- Event priority, highest first: memory wait, then load-use, then flush.
- Memory wait:
  - In RUN, if mem_access=1 and mem_ready=0, go to MEM_WAIT in the same cycle.
  - The freeze is combinational in this cycle: pc_write, if_id_write, id_ex_write and ex_mem_write are 0; mem_wb_bubble=1.
  - In MEM_WAIT the same freeze holds and the wait counter increments each cycle.
  - mem_ready=1 releases the freeze in that cycle: all writes=1, mem_wb_bubble=0; next state is RUN.
  - mem_access=1 with mem_ready=1 in RUN means zero wait, with no freeze.
- Timeout:
  - When the counter reaches MEM_TIMEOUT-1 without mem_ready, go to ABORT and set mem_err (sticky until rst).
  - ABORT lasts one cycle: writes enabled, mem_wb_bubble=1 (the access is dropped), mem_req=0. Then go to RUN.
- Load-use:
  - Hazard = ex_mem_read && ex_rd!=0 && ((id_use_rs1 && ex_rd==id_rs1) || (id_use_rs2 && ex_rd==id_rs2)).
  - Response: pc_write=0, if_id_write=0, id_ex_bubble=1; the other stages advance.
  - flush_req is ignored during a load-use stall, because the branch compare is invalid; it is re-evaluated next cycle.
- Flush:
  - flush_req=1 with no higher-priority event gives if_id_flush=1 and pc_write=1.
  - flush_req=1 arriving during MEM_WAIT sets flush_pending. At release, if_id_flush=1 is asserted in the release cycle and flush_pending is cleared.
- rst asserted mid-MEM_WAIT returns to RUN next cycle; a pending flush is discarded.

Optional Feature:
- HAZARD_PERF_EN defined:
  - stall_cycles increments on every cycle with pc_write=0 and rst=0.
  - flush_count increments on every cycle with if_id_flush=1 and rst=0.
  - Both counters saturate at all-ones and clear on rst.
- HAZARD_PERF_EN undefined: both ports are tied to 0 and no counter registers are inferred.

Test Plan:
- Load x5 in EX (ex_mem_read=1, ex_rd=5), ID reads rs2=5 -> exactly one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; then normal.
- Same as above but ex_rd=0 -> no stall.
- mem_access=1, mem_ready low for 3 cycles then high -> 3 frozen cycles with mem_req=1 and mem_wb_bubble=1; release in cycle 4 with all writes=1.
- flush_req pulsed in wait cycle 2 of a 4-cycle MEM_WAIT -> if_id_flush=1 only in the release cycle; with HAZARD_PERF_EN, flush_count=1.
- Load-use hazard and flush_req=1 in the same cycle -> stall asserted, if_id_flush=0.
- mem_ready never asserted, MEM_TIMEOUT=16 -> 15 wait cycles, then ABORT with mem_wb_bubble=1; mem_err=1 until rst, then mem_err=0 and stall_cycles=0.
